// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between W-stage writeback and a buffered long-latency return path,
// and keeps a pending-destination scoreboard for Decode stalls. Optional starvation guard: RF_ARB_STARVE_GUARD_EN.
module regfile_write_arbiter #(
  parameter int WIDTH        = 64,
  parameter int NREGS        = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             lu_issue,
  input  logic [4:0]       lu_issue_addr,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [4:0]       lu_addr,
  input  logic [WIDTH-1:0] lu_data,
  input  logic [4:0]       RA1D,
  input  logic [4:0]       RA2D,
  input  logic             ra1_used,
  input  logic             ra2_used,
  output logic             stall_d,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             wb_hold_req
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshake: a return transfers on the rising edge where lu_valid & lu_ready are both high;
  // lu_ready depends only on the registered fill count, never on lu_valid.
  logic [4:0]       fifo_addr [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [NREGS-1:0] pending, pending_next;
  logic             fifo_empty, push, pop;

  assign fifo_empty = (count == '0);
  assign lu_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = lu_valid & lu_ready;
  assign pop        = ~wb_valid & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lu_addr;
      fifo_data[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pipeline writeback always wins; the buffer only drains into idle slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (wb_valid) begin
      we3 <= 1'b1;
      wa3 <= wb_addr;
      wd3 <= wb_data;
    end else if (pop) begin
      we3 <= 1'b1;
      wa3 <= fifo_addr[rd_ptr];
      wd3 <= fifo_data[rd_ptr];
    end else begin
      we3 <= 1'b0;
    end
  end

  // A new issue beats a same-cycle clear; r31 is PC-linked and never tracked.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[fifo_addr[rd_ptr]] = 1'b0;
    if (lu_issue && (lu_issue_addr != 5'd31)) pending_next[lu_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  assign stall_d = (ra1_used & pending[RA1D]) |
                   (ra2_used & pending[RA2D]) |
                   (lu_issue & pending[lu_issue_addr]);

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic          hold;
  logic          blocked;

  assign blocked = wb_valid & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset || pop) begin
      starve_cnt <= '0;
      hold       <= 1'b0;
    end else if (blocked) begin
      if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
      if (starve_cnt >= SW'(STARVE_LIMIT - 1)) hold <= 1'b1;
    end
  end

  assign wb_hold_req = hold;
`else
  assign wb_hold_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: write-port priority, buffer back-pressure,
// scoreboard stalls and the optional W-stage hold request.
module tb_regfile_write_arbiter;
  localparam int WIDTH = 64;
`ifdef RF_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk, reset;
  logic             wb_valid, lu_issue, lu_valid, lu_ready;
  logic [4:0]       wb_addr, lu_issue_addr, lu_addr, RA1D, RA2D, wa3;
  logic [WIDTH-1:0] wb_data, lu_data, wd3;
  logic             ra1_used, ra2_used, stall_d, we3, wb_hold_req;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_write_arbiter #(.WIDTH(WIDTH), .NREGS(32), .FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .RA1D(RA1D), .RA2D(RA2D), .ra1_used(ra1_used), .ra2_used(ra2_used),
    .stall_d(stall_d), .we3(we3), .wa3(wa3), .wd3(wd3), .wb_hold_req(wb_hold_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    lu_issue = 0; lu_issue_addr = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
    RA1D = 0; RA2D = 0; ra1_used = 0; ra2_used = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    step();
  endtask

  logic       exp_ready [5]  = '{1, 1, 0, 0, 1};
  logic       exp_we    [7]  = '{1, 1, 1, 1, 1, 1, 0};
  logic [4:0] exp_wa    [6]  = '{20, 21, 22, 10, 11, 12};
  logic [8:0] exp_wd    [6]  = '{9'h100, 9'h101, 9'h102, 9'h200, 9'h201, 9'h202};

  initial begin
    int idx;
    idle_inputs();
    do_reset();

    // Reset state and idle
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_hold", wb_hold_req, 0);
    check("rst_lu_ready", lu_ready, 1);
    ra1_used = 1; ra2_used = 1;
    for (int r = 0; r < 32; r++) begin
      RA1D = 5'(r); RA2D = 5'(31 - r);
      #1 check("rst_stall", stall_d, 0);
    end
    ra1_used = 0; ra2_used = 0;

    // Pipeline writeback
    wb_valid = 1; wb_addr = 5; wb_data = 64'hAA;
    step();
    wb_valid = 0;
    check("wb_we3", we3, 1);
    check("wb_wa3", wa3, 5);
    check("wb_wd3", wd3, 64'hAA);
    step();
    check("wb_we3_off", we3, 0);

    // Scoreboard RAW stall and clear on return
    lu_issue = 1; lu_issue_addr = 7;
    #1 check("issue7_no_stall", stall_d, 0);
    step();
    lu_issue = 0; RA1D = 7; ra1_used = 1;
    #1 check("raw7_stall", stall_d, 1);
    ra1_used = 0;
    #1 check("raw7_unused", stall_d, 0);
    ra1_used = 1;
    lu_valid = 1; lu_addr = 7; lu_data = 64'h1234;
    #1 check("ret7_ready", lu_ready, 1);
    step();
    lu_valid = 0;
    step();
    check("ret7_we3", we3, 1);
    check("ret7_wa3", wa3, 7);
    check("ret7_wd3", wd3, 64'h1234);
    check("ret7_stall_clear", stall_d, 0);
    step();
    check("ret7_we3_off", we3, 0);
    ra1_used = 0;

    // Simultaneous writeback and return
    wb_valid = 1; wb_addr = 3; wb_data = 64'h11;
    lu_valid = 1; lu_addr = 9; lu_data = 64'h22;
    step();
    wb_valid = 0; lu_valid = 0;
    check("sim_wa3_n1", wa3, 3);
    check("sim_wd3_n1", wd3, 64'h11);
    step();
    check("sim_we3_n2", we3, 1);
    check("sim_wa3_n2", wa3, 9);
    check("sim_wd3_n2", wd3, 64'h22);
    step();
    check("sim_idle", we3, 0);

    // Back-pressure: writeback held 3 cycles, returns offered every cycle
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      wb_valid = (c < 3);
      wb_addr  = 5'(20 + c);
      wb_data  = 64'(9'h100 + c);
      lu_valid = (idx < 3);
      lu_addr  = 5'(10 + idx);
      lu_data  = 64'(9'h200 + idx);
      #1;
      if (c < 5) check($sformatf("bp_ready_c%0d", c), lu_ready, exp_ready[c]);
      step();
      if (lu_valid && exp_ready[c < 5 ? c : 4]) idx++;
      check($sformatf("bp_we3_c%0d", c), we3, exp_we[c]);
      if (c < 6) begin
        check($sformatf("bp_wa3_c%0d", c), wa3, exp_wa[c]);
        check($sformatf("bp_wd3_c%0d", c), wd3, 64'(exp_wd[c]));
      end
    end
    idle_inputs();

    // WAW stall on pending destination, r31 never pending
    lu_issue = 1; lu_issue_addr = 4;
    step();
    #1 check("waw4_stall", stall_d, 1);
    lu_issue_addr = 31;
    #1 check("issue31_no_stall", stall_d, 0);
    step();
    lu_issue = 0; RA2D = 31; ra2_used = 1;
    #1 check("r31_not_pending", stall_d, 0);
    RA2D = 4;
    #1 check("r4_pending", stall_d, 1);

    // Return for r4 while r4 is reissued in its pop cycle: set wins
    lu_valid = 1; lu_addr = 4; lu_data = 64'h44;
    step();
    lu_valid = 0; lu_issue = 1; lu_issue_addr = 4;
    step();
    lu_issue = 0;
    check("r4_ret_wa3", wa3, 4);
    #1 check("r4_set_wins", stall_d, 1);

    // Writes to r31 pass through unchanged
    wb_valid = 1; wb_addr = 31; wb_data = 64'h55;
    step();
    wb_valid = 0;
    check("r31_wa3", wa3, 31);
    check("r31_wd3", wd3, 64'h55);

    do_reset();
    #1 check("rst_clears_pending", stall_d, 0);
    ra2_used = 0;

    // Starvation: one buffered return blocked by continuous writeback
    wb_valid = 1; wb_addr = 1; wb_data = 64'h1;
    lu_valid = 1; lu_addr = 15; lu_data = 64'hF0;
    step();
    lu_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 7) check("starve_hold_7", wb_hold_req, 0);
      if (c == 8) check("starve_hold_8", wb_hold_req, GUARD);
    end
    wb_valid = 0;
    step();
    check("starve_pop_wa3", wa3, 15);
    check("starve_hold_clear", wb_hold_req, 0);

    // Reset discards buffered returns
    wb_valid = 1; lu_valid = 1; lu_addr = 16; lu_data = 64'h16;
    step();
    wb_valid = 0; lu_valid = 0;
    reset = 1;
    step();
    reset = 0;
    check("midrst_we3", we3, 0);
    step();
    check("midrst_discard", we3, 0);
    check("midrst_ready", lu_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
